mul_seq_ctrl: RTL and testbench
===============================

Name: mul_seq_ctrl

Overview:
- Iterative shift-add multiply controller: accepts one 16x16 unsigned operand pair over a valid/ready handshake and sequences WIDTH add/shift steps.
- Returns the 32-bit product split into low half (l_m) and high half (r_m) over a second valid/ready handshake.
- Sits between the instruction sequencer and the register writeback path; low-area alternative to the single-cycle multiplier.

Parameters:
WIDTH, 16, operand width; product is 2*WIDTH bits, split into two WIDTH-bit halves.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand pair a/b valid.
in_ready  output  1  controller can accept operands.
a  input  WIDTH  multiplicand, unsigned.
b  input  WIDTH  multiplier, unsigned.
out_valid  output  1  l_m/r_m hold a completed product.
out_ready  input  1  consumer accepts the product.
l_m  output  WIDTH  product bits [WIDTH-1:0].
r_m  output  WIDTH  product bits [2*WIDTH-1:WIDTH].
busy  output  1  high while state is RUN.

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst).
- Reset: state IDLE, acc=0, mcand=0, mplier=0, count=0, out_valid=0, busy=0, l_m=0, r_m=0, in_ready=1.
- Registers:
  - acc: 2*WIDTH bits.
  - mcand: 2*WIDTH bits, zero-extended a.
  - mplier: WIDTH bits.
  - count: $clog2(WIDTH+1) bits.
- Output mapping: l_m=acc[WIDTH-1:0], r_m=acc[2*WIDTH-1:WIDTH]; both are registered, with no combinational path from a/b.
- in_ready = (state==IDLE). out_valid = (state==DONE). busy = (state==RUN).
- IDLE:
  - On in_valid&in_ready: mcand<={0,a}, mplier<=b, acc<=0, count<=0, go to RUN.
  - Otherwise hold; acc keeps the previous result.
- RUN, once per cycle:
  - If mplier[0]: acc<=acc+mcand (modulo 2^(2*WIDTH); overflow is impossible).
  - mcand<=mcand<<1; mplier<=mplier>>1; count<=count+1.
  - When count==WIDTH-1 on this edge, go to DONE.
- DONE:
  - Hold acc stable.
  - On out_ready, go to IDLE. Otherwise stay indefinitely; in_valid is ignored.
- Latency: accept cycle = cycle 0; RUN occupies cycles 1..WIDTH; out_valid first high in cycle WIDTH+1.
- Throughput: one product per WIDTH+2 cycles minimum. No accept in the same cycle as the out handshake.
- a/b are sampled only on the accept cycle; later changes have no effect.
- rst asserted in any state (including mid-RUN) aborts immediately to reset values; the partial product is discarded.

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined:
  - On accept with b==0: go directly to DONE with acc=0; out_valid in cycle 1.
  - In RUN: go to DONE on the edge where the next mplier value (mplier>>1) is zero, or count==WIDTH-1.
  - Result: out_valid in cycle msb_index(b)+2.
- Undefined: fixed WIDTH-cycle RUN for all operands; b==0 still takes WIDTH+1 cycles.
- Results are identical in both builds; only latency differs.

Decomposition:
- Package mul_pkg:
  - state typedef {IDLE, RUN, DONE}.
  - WIDTH default constant.
  - count width constant.
- Natural sub-module mul_seq_datapath:
  - Holds acc/mcand/mplier and performs the add/shift step.
  - Controlled by load/step strobes.
  - Exports mplier_zero_next.
- The FSM and handshakes stay in mul_seq_ctrl.

Test Plan:
- Reset: rst pulse -> out_valid=0, busy=0, in_ready=1, l_m=0x0000, r_m=0x0000.
- Basic: a=0x1234, b=0x5678 -> out_valid in cycle 17; r_m=0x0626, l_m=0x0060.
- Max operands: a=0xFFFF, b=0xFFFF -> r_m=0xFFFE, l_m=0x0001. Also a=0, b=0xFFFF -> r_m=0x0000, l_m=0x0000.
- Backpressure: out_ready low 5 cycles after out_valid, in_valid=1 with new a/b:
  - in_ready stays 0; l_m/r_m stay stable; second op not accepted.
  - Second op accepted in the first IDLE cycle after the handshake.
- Reset mid-operation: rst asserted in cycle 8 of RUN -> outputs 0 and IDLE immediately. Next op a=3, b=5 -> l_m=0x000F, r_m=0.
- Early exit (MUL_EARLY_EXIT_EN):
  - a=0x00FF, b=0x0001 -> l_m=0x00FF in cycle 2.
  - b=0 -> 0 in cycle 1.
  - Without the macro, both in cycle 17.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and default sizing for the sequential shift-add multiplier.
// Optional feature macro used by this slice: MUL_EARLY_EXIT_EN.
package mul_pkg;

    // Default operand width; the product is twice this wide.
    localparam int unsigned MUL_WIDTH = 16;

    // Step counter width for the default operand width.
    localparam int unsigned MUL_CNT_W = $clog2(MUL_WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_seq_datapath.sv
// Shift-add datapath: holds the accumulator, the multiplicand and the multiplier.
// It loads a fresh operand pair on load_i and performs one add/shift step on step_i.
module mul_seq_datapath
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               mplier_zero_next_o
);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;

    // Load the operands, or add the shifted multiplicand when the current multiplier bit is set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (load_i) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
        end else if (step_i) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

    // The remaining multiplier bits are all zero after this step, so later steps would add nothing.
    always_comb begin
        mplier_zero_next_o = (mplier_q[WIDTH-1:1] == '0);
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Iterative 16x16 shift-add multiply controller with valid/ready handshakes on both sides.
// Optional feature: define MUL_EARLY_EXIT_EN to end the run once the multiplier runs out of
// set bits (and skip the run entirely for b == 0). Results are identical either way.
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] l_m,
    output logic [WIDTH-1:0] r_m,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    mul_state_e         state_q;
    logic [CntW-1:0]    count_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic               load;
    logic               step;
    logic               last_step;
    logic               mplier_zero_next;
    logic [2*WIDTH-1:0] acc;

    assign load = in_valid & (state_q == StIdle);
    assign step = (state_q == StRun);

`ifdef MUL_EARLY_EXIT_EN
    assign last_step = (count_q == CntW'(WIDTH - 1)) | mplier_zero_next;
`else
    logic unused_mplier_zero_next;
    assign unused_mplier_zero_next = mplier_zero_next;
    assign last_step = (count_q == CntW'(WIDTH - 1));
`endif

    mul_seq_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk_i              (clk),
        .rst_i              (rst),
        .load_i             (load),
        .step_i             (step),
        .a_i                (a),
        .b_i                (b),
        .acc_o              (acc),
        .mplier_zero_next_o (mplier_zero_next)
    );

    // Sequencing FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        count_q    <= '0;
                        in_ready_q <= 1'b0;
`ifdef MUL_EARLY_EXIT_EN
                        if (b == '0) begin
                            // Product is already known to be zero; acc is cleared by the load.
                            state_q     <= StDone;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                        end
`else
                        state_q <= StRun;
                        busy_q  <= 1'b1;
`endif
                    end
                end
                StRun: begin
                    count_q <= count_q + CntW'(1);
                    if (last_step) begin
                        state_q     <= StDone;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign l_m       = acc[WIDTH-1:0];
    assign r_m       = acc[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: table of directed operand pairs plus hand-written
// backpressure and mid-run reset sequences. Honours MUL_EARLY_EXIT_EN for expected latency.
module tb_mul_seq_ctrl;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] l_m;
    logic [W-1:0] r_m;
    logic         busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mul_seq_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .l_m       (l_m),
        .r_m       (r_m),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_l;
        logic [W-1:0] exp_r;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Cycle (counted from the accept cycle) in which out_valid first rises.
    function automatic int exp_lat(input logic [W-1:0] bv);
`ifdef MUL_EARLY_EXIT_EN
        int msb;
        if (bv == '0) return 1;
        msb = 0;
        for (int i = 0; i < int'(W); i++) begin
            if (bv[i]) msb = i;
        end
        return msb + 2;
`else
        return int'(W) + 1;
`endif
    endfunction

    // Present one operand pair, wait for the product and return its latency.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, output int lat);
        @(negedge clk);
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_after_handshake", {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        int lat;
        logic [W-1:0] held_l;
        logic [W-1:0] held_r;

        vecs[0] = '{16'h1234, 16'h5678, 16'h0060, 16'h0626};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE};
        vecs[2] = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
        vecs[3] = '{16'h0003, 16'h0005, 16'h000F, 16'h0000};
        vecs[4] = '{16'h00FF, 16'h0001, 16'h00FF, 16'h0000};
        vecs[5] = '{16'h1234, 16'h0000, 16'h0000, 16'h0000};
        vecs[6] = '{16'h8000, 16'h0002, 16'h0000, 16'h0001};
        vecs[7] = '{16'hABCD, 16'h0100, 16'hCD00, 16'h00AB};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_l_m", {16'd0, l_m}, 32'd0);
        chk("reset_r_m", {16'd0, r_m}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].a, vecs[i].b, lat);
            chk($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].b));
            chk($sformatf("vec%0d_l_m", i), {16'd0, l_m}, {16'd0, vecs[i].exp_l});
            chk($sformatf("vec%0d_r_m", i), {16'd0, r_m}, {16'd0, vecs[i].exp_r});
            chk($sformatf("vec%0d_busy_done", i), {31'd0, busy}, 32'd0);
            consume();
            // Result stays visible in IDLE until the next accept.
            chk($sformatf("vec%0d_l_m_idle", i), {16'd0, l_m}, {16'd0, vecs[i].exp_l});
        end

        // Backpressure: product held while a new request waits.
        issue(16'h0002, 16'h0003, lat);
        chk("bp_first_latency", lat, exp_lat(16'h0003));
        held_l   = l_m;
        held_r   = r_m;
        in_valid = 1'b1;
        a        = 16'h0007;
        b        = 16'h0009;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_in_ready_%0d", i), {31'd0, in_ready}, 32'd0);
            chk($sformatf("bp_out_valid_%0d", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp_result_%0d", i), {r_m, l_m}, 32'h0000_0006);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_idle_result_held", {r_m, l_m}, {held_r, held_l});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_second_accepted", {30'd0, in_ready, busy}, 32'd1);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_second_latency", lat, exp_lat(16'h0009));
        chk("bp_second_result", {r_m, l_m}, 32'h0000_003F);
        consume();

        // Reset in the middle of a run discards the partial product.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'h1234;
        b        = 16'h5678;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("midrun_busy_before_rst", {31'd0, busy}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("midrun_rst_flags", {29'd0, in_ready, out_valid, busy}, 32'd4);
        chk("midrun_rst_result", {r_m, l_m}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(16'h0003, 16'h0005, lat);
        chk("after_rst_latency", lat, exp_lat(16'h0005));
        chk("after_rst_result", {r_m, l_m}, 32'h0000_000F);
        consume();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
